// File: rtl/uar_rx_fifo_if.sv
// Host-facing bundle for the uar receive FIFO: frame inputs from the uar,
// host read/clear controls, and the FIFO's read and status outputs.
interface uar_rx_fifo_if #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int ERR_CNT_W  = 8
);
    logic [DATA_W-1:0]    dIn;
    logic                 dReady;
    logic                 dError;
    logic                 rd_en;
    logic                 clr_ovr;
    logic [DATA_W-1:0]    rd_data;
    logic                 rd_valid;
    logic                 empty;
    logic                 full;
    logic [DEPTH_LOG2:0]  level;
    logic                 overrun;
    logic [ERR_CNT_W-1:0] err_cnt;

    // Side that feeds frames and issues reads (uar + host).
    modport master (
        output dIn, dReady, dError, rd_en, clr_ovr,
        input  rd_data, rd_valid, empty, full, level, overrun, err_cnt
    );

    // The FIFO itself.
    modport slave (
        input  dIn, dReady, dError, rd_en, clr_ovr,
        output rd_data, rd_valid, empty, full, level, overrun, err_cnt
    );
endinterface

// File: rtl/uar_rx_fifo.sv
// Receive buffer behind the uar: one capture per dReady rising edge, good
// bytes into a DEPTH-entry FIFO, error frames discarded and counted, sticky
// overrun when a good byte meets a full FIFO, registered host read port.
module uar_rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int ERR_CNT_W  = 8
) (
    input  logic          clk,
    input  logic          gl_reset,
    uar_rx_fifo_if.slave  bus
);
    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LVL_ONE  = 1;
    localparam logic [DEPTH_LOG2:0] LVL_FULL = DEPTH;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
    localparam logic [ERR_CNT_W-1:0]  ERR_ONE = 1;

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_rdy_q;
    logic                  r_overrun;
    logic [ERR_CNT_W-1:0]  r_err_cnt;
    logic [DATA_W-1:0]     r_rd_data;
    logic                  r_rd_valid;

    logic                  w_frame_evt;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_ovr_evt;
    logic                  w_err_evt;
    logic [DEPTH_LOG2:0]   w_level_nxt;

    // A read frees a slot in the same cycle, so a full FIFO can still
    // accept a good frame when the host reads alongside it.
    assign w_frame_evt = bus.dReady & ~r_rdy_q;
    assign w_rd_acc    = bus.rd_en & ~r_empty;
    assign w_err_evt   = w_frame_evt & bus.dError;
    assign w_wr_acc    = w_frame_evt & ~bus.dError & (~r_full | w_rd_acc);
    assign w_ovr_evt   = w_frame_evt & ~bus.dError & r_full & ~w_rd_acc;

    // Next occupancy: +1 write only, -1 read only, hold otherwise.
    always_comb begin
        // NOTE: default first so every path assigns it and no latch is inferred.
        w_level_nxt = r_level;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_level_nxt = r_level + LVL_ONE;
            2'b01:   w_level_nxt = r_level - LVL_ONE;
            default: w_level_nxt = r_level;
        endcase
    end

    // Byte storage; the read port picks up the old entry even when the same
    // slot is rewritten this cycle (full FIFO with simultaneous read+write).
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; the pointers and level define what is valid.
        if (w_wr_acc)
            r_mem[r_wr_ptr] <= bus.dIn;
    end

    // Pointers, occupancy flags, edge detector and read register.
    always_ff @(posedge clk) begin
        if (gl_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            // Start "high" so a dReady already asserted across reset is not a new frame.
            r_rdy_q    <= 1'b1;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            r_rdy_q    <= bus.dReady;
            r_level    <= w_level_nxt;
            r_empty    <= (w_level_nxt == '0);
            r_full     <= (w_level_nxt == LVL_FULL);
            r_rd_valid <= w_rd_acc;
            if (w_wr_acc)
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd_acc) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Sticky overrun (a same-cycle event beats clr_ovr) and saturating error count.
    always_ff @(posedge clk) begin
        if (gl_reset) begin
            r_overrun <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_ovr_evt)
                r_overrun <= 1'b1;
            else if (bus.clr_ovr)
                r_overrun <= 1'b0;
            if (w_err_evt && (r_err_cnt != '1))
                r_err_cnt <= r_err_cnt + ERR_ONE;
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.empty    = r_empty;
    assign bus.full     = r_full;
    assign bus.level    = r_level;
    assign bus.overrun  = r_overrun;
    assign bus.err_cnt  = r_err_cnt;
endmodule

// File: tb/tb_uar_rx_fifo.sv
// Bench for uar_rx_fifo: directed frames and reads; expected read bytes go
// into a scoreboard queue that a negedge monitor pops on every rd_valid.
module tb_uar_rx_fifo;
    logic clk = 1'b0;
    logic gl_reset;

    always #5 clk = ~clk;

    uar_rx_fifo_if bus_if ();

    uar_rx_fifo dut (
        .clk      (clk),
        .gl_reset (gl_reset),
        .bus      (bus_if)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] model_q[$];
    logic [7:0] exp_q[$];
    int         err_model = 0;
    bit         ovr_model = 1'b0;
    logic [7:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_level"},   32'(bus_if.level),   32'(model_q.size()));
        check({tag, "_empty"},   32'(bus_if.empty),   32'(model_q.size() == 0));
        check({tag, "_full"},    32'(bus_if.full),    32'(model_q.size() == 16));
        check({tag, "_overrun"}, 32'(bus_if.overrun), 32'(ovr_model));
        check({tag, "_err_cnt"}, 32'(bus_if.err_cnt), 32'(err_model));
    endtask

    // Reference behaviour for one cycle carrying a frame event and/or a read.
    task automatic model_cycle(input logic [7:0] d, input bit err, input bit rd, input bit clr);
        bit was_full;
        bit rd_acc;
        was_full = (model_q.size() == 16);
        rd_acc   = rd && (model_q.size() > 0);
        if (clr) ovr_model = 1'b0;
        if (rd_acc) exp_q.push_back(model_q.pop_front());
        if (err) begin
            if (err_model < 255) err_model++;
        end else if (!was_full || rd_acc) begin
            model_q.push_back(d);
        end else begin
            ovr_model = 1'b1;
        end
    endtask

    task automatic frame(input logic [7:0] d, input bit err);
        @(negedge clk);
        bus_if.dIn = d; bus_if.dError = err; bus_if.dReady = 1'b1;
        model_cycle(d, err, 1'b0, 1'b0);
        @(negedge clk);
        bus_if.dReady = 1'b0; bus_if.dError = 1'b0;
    endtask

    task automatic frame_rd(input logic [7:0] d);
        @(negedge clk);
        bus_if.dIn = d; bus_if.dError = 1'b0; bus_if.dReady = 1'b1; bus_if.rd_en = 1'b1;
        model_cycle(d, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        bus_if.dReady = 1'b0; bus_if.rd_en = 1'b0;
    endtask

    task automatic rd();
        @(negedge clk);
        bus_if.rd_en = 1'b1;
        if (model_q.size() > 0) exp_q.push_back(model_q.pop_front());
        @(negedge clk);
        bus_if.rd_en = 1'b0;
    endtask

    // Monitor: every rd_valid pulse must match the oldest expected byte.
    initial begin
        forever begin
            @(negedge clk);
            if (bus_if.rd_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rd_valid_unexpected: got rd_data 0x%0h expected no read", bus_if.rd_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("rd_data", 32'(bus_if.rd_data), 32'(mon_exp));
                end
            end
        end
    end

    initial begin
        gl_reset = 1'b1;
        bus_if.dIn = '0; bus_if.dReady = 1'b0; bus_if.dError = 1'b0;
        bus_if.rd_en = 1'b0; bus_if.clr_ovr = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rd_data",  32'(bus_if.rd_data),  32'h0);
        check("reset_rd_valid", 32'(bus_if.rd_valid), 32'h0);
        check_state("reset");
        gl_reset = 1'b0;

        // 1. two good frames, read back in order, then an ignored read while empty
        frame(8'h55, 1'b0);
        frame(8'hA3, 1'b0);
        check_state("t1_two");
        rd();
        rd();
        check_state("t1_drained");
        rd();
        check("t1_rd_data_hold", 32'(bus_if.rd_data), 32'hA3);
        check_state("t1_empty_read");

        // 2. dReady held high for 20 cycles is a single frame
        @(negedge clk);
        bus_if.dIn = 8'h3C; bus_if.dReady = 1'b1;
        model_cycle(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        bus_if.dReady = 1'b0;
        check_state("t2_long_ready");
        rd();

        // empty FIFO, frame and rd_en together: write happens, read ignored
        frame_rd(8'h6B);
        check_state("t2_empty_wr_rd");
        rd();
        check_state("t2_after");

        // 3. error frames are counted, not stored, and the count saturates
        frame(8'h7E, 1'b1);
        check_state("t3_one_err");
        for (int i = 0; i < 256; i++) frame(8'(i), 1'b1);
        check_state("t3_saturated");

        // 4. fill, overrun, clr_ovr losing to a same-cycle overrun, drain, clear
        for (int i = 0; i < 16; i++) frame(8'(8'h20 + i), 1'b0);
        check_state("t4_full");
        frame(8'h99, 1'b0);
        check_state("t4_overrun");
        @(negedge clk);
        bus_if.dIn = 8'h9A; bus_if.dReady = 1'b1; bus_if.clr_ovr = 1'b1;
        model_cycle(8'h9A, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        bus_if.dReady = 1'b0; bus_if.clr_ovr = 1'b0;
        check_state("t4_clr_vs_ovr");
        for (int i = 0; i < 16; i++) rd();
        check_state("t4_drained");
        @(negedge clk);
        bus_if.clr_ovr = 1'b1; ovr_model = 1'b0;
        @(negedge clk);
        bus_if.clr_ovr = 1'b0;
        check_state("t4_cleared");

        // 5. full FIFO with simultaneous frame and read, then wrap-around traffic
        for (int i = 0; i < 16; i++) frame(8'(8'h40 + i), 1'b0);
        frame_rd(8'hC5);
        check_state("t5_full_wr_rd");
        for (int i = 0; i < 40; i++) frame_rd(8'(i * 5 + 1));
        check_state("t5_wrap");
        for (int i = 0; i < 16; i++) rd();
        check_state("t5_drained");

        // 6. reset mid-operation with dReady held high
        for (int i = 0; i < 4; i++) frame(8'(8'h10 + i), 1'b0);
        @(negedge clk);
        bus_if.dIn = 8'h14; bus_if.dReady = 1'b1;
        model_cycle(8'h14, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_state("t6_level5");
        gl_reset = 1'b1;
        model_q.delete(); ovr_model = 1'b0; err_model = 0;
        repeat (2) @(negedge clk);
        gl_reset = 1'b0;
        repeat (5) @(negedge clk);
        check_state("t6_after_reset");
        bus_if.dReady = 1'b0;
        @(negedge clk);
        frame(8'h42, 1'b0);
        check_state("t6_new_frame");
        rd();

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
